// File: rtl/vend_ctrl.sv
// Vending controller: coin credit accumulation, per-product price/stock tables,
// dispense and change sequencing with one-cycle result pulses.
module vend_ctrl #(
    parameter int unsigned CW    = 8,
    parameter int unsigned NPROD = 6,
    parameter int unsigned SW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          coin_valid_i,
    input  logic [CW-1:0] coin_val_i,
    input  logic          buy_valid_i,
    input  logic [2:0]    buy_sel_i,
    input  logic          cancel_i,
    input  logic          cfg_we_i,
    input  logic [2:0]    cfg_addr_i,
    input  logic [CW-1:0] cfg_price_i,
    input  logic          restock_i,
    output logic          coin_ack_o,
    output logic [CW-1:0] credit_o,
    output logic          busy_o,
    output logic          vend_valid_o,
    output logic [2:0]    vend_type_o,
    output logic          change_valid_o,
    output logic [CW-1:0] change_o,
    output logic          err_valid_o,
    output logic [1:0]    err_code_o
);

    localparam int unsigned IW     = (NPROD < 2) ? 1 : $clog2(NPROD + 1);
    localparam logic [SW-1:0] SMAX = '1;
    localparam logic [1:0] ERR_OVF     = 2'd0;
    localparam logic [1:0] ERR_BADSEL  = 2'd1;
    localparam logic [1:0] ERR_SOLDOUT = 2'd2;
    localparam logic [1:0] ERR_FUNDS   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        VEND   = 2'd2,
        REFUND = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [2:0]    sel_q, sel_d;
    logic [CW-1:0] price_q [1:NPROD];
    logic [CW-1:0] price_d [1:NPROD];
    logic [SW-1:0] stock_q [1:NPROD];
    logic [SW-1:0] stock_d [1:NPROD];
    logic          busy_q, busy_d;
    logic          vend_valid_q, vend_valid_d;
    logic [2:0]    vend_type_q, vend_type_d;
    logic          change_valid_q, change_valid_d;
    logic [CW-1:0] change_q, change_d;
    logic          err_valid_q, err_valid_d;
    logic [1:0]    err_code_q, err_code_d;

    logic [CW:0]   coin_sum;
    logic          sel_ok;
    logic [CW-1:0] req_price;
    logic [SW-1:0] req_stock;
    logic [CW-1:0] vend_price;

    function automatic logic [CW-1:0] reset_price(input int unsigned idx);
        case (idx)
            1:       return CW'(110);
            2:       return CW'(150);
            3:       return CW'(190);
            4:       return CW'(230);
            5:       return CW'(243);
            6:       return CW'(30);
            default: return '0;
        endcase
    endfunction

    // Table lookups for the requested product and the product being vended
    always_comb begin
        sel_ok     = 1'b0;
        req_price  = '0;
        req_stock  = '0;
        vend_price = '0;
        for (int unsigned i = 1; i <= NPROD; i++) begin
            if (buy_sel_i == 3'(i)) begin
                sel_ok    = 1'b1;
                req_price = price_q[IW'(i)];
                req_stock = stock_q[IW'(i)];
            end
            if (sel_q == 3'(i)) begin
                vend_price = price_q[IW'(i)];
            end
        end
    end

    assign coin_sum = {1'b0, credit_q} + {1'b0, coin_val_i};

    // Next-state and registered-output computation
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        sel_d          = sel_q;
        price_d        = price_q;
        stock_d        = stock_q;
        vend_valid_d   = 1'b0;
        vend_type_d    = '0;
        change_valid_d = 1'b0;
        change_d       = '0;
        err_valid_d    = 1'b0;
        err_code_d     = '0;
        coin_ack_o     = 1'b0;

        case (state_q)
            IDLE, ACCUM: begin
                if (cancel_i) begin
                    if (state_q == ACCUM) begin
                        state_d = REFUND;
                    end
                end else if (buy_valid_i) begin
                    if (!sel_ok) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_BADSEL;
                    end else if (req_stock == '0) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_SOLDOUT;
                    end else if (credit_q < req_price) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_FUNDS;
                    end else begin
                        state_d = VEND;
                        sel_d   = buy_sel_i;
                    end
                end else if (coin_valid_i) begin
                    if (coin_sum[CW]) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_OVF;
                    end else begin
                        coin_ack_o = 1'b1;
                        credit_d   = coin_sum[CW-1:0];
                        if (coin_val_i != '0) begin
                            state_d = ACCUM;
                        end
                    end
                end

                // Table maintenance is only allowed with no customer session open
                if (state_q == IDLE) begin
                    for (int unsigned i = 1; i <= NPROD; i++) begin
                        if (cfg_we_i && cfg_addr_i == 3'(i)) begin
                            price_d[IW'(i)] = cfg_price_i;
                        end
                        if (restock_i) begin
                            stock_d[IW'(i)] = SMAX;
                        end
                    end
                end
            end

            VEND: begin
                vend_valid_d = 1'b1;
                vend_type_d  = sel_q;
                credit_d     = credit_q - vend_price;
                for (int unsigned i = 1; i <= NPROD; i++) begin
                    if (sel_q == 3'(i) && stock_q[IW'(i)] != '0) begin
                        stock_d[IW'(i)] = stock_q[IW'(i)] - SW'(1);
                    end
                end
                state_d = (credit_d != '0) ? REFUND : IDLE;
            end

            REFUND: begin
                change_valid_d = 1'b1;
                change_d       = credit_q;
                credit_d       = '0;
                state_d        = IDLE;
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d == VEND) || (state_d == REFUND);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            sel_q          <= '0;
            busy_q         <= 1'b0;
            vend_valid_q   <= 1'b0;
            vend_type_q    <= '0;
            change_valid_q <= 1'b0;
            change_q       <= '0;
            err_valid_q    <= 1'b0;
            err_code_q     <= '0;
            for (int unsigned i = 1; i <= NPROD; i++) begin
                price_q[IW'(i)] <= reset_price(i);
                stock_q[IW'(i)] <= SMAX;
            end
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            sel_q          <= sel_d;
            busy_q         <= busy_d;
            vend_valid_q   <= vend_valid_d;
            vend_type_q    <= vend_type_d;
            change_valid_q <= change_valid_d;
            change_q       <= change_d;
            err_valid_q    <= err_valid_d;
            err_code_q     <= err_code_d;
            price_q        <= price_d;
            stock_q        <= stock_d;
        end
    end

    assign credit_o       = credit_q;
    assign busy_o         = busy_q;
    assign vend_valid_o   = vend_valid_q;
    assign vend_type_o    = vend_type_q;
    assign change_valid_o = change_valid_q;
    assign change_o       = change_q;
    assign err_valid_o    = err_valid_q;
    assign err_code_o     = err_code_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl: coin/buy/cancel/config sequences with
// hand-computed expectations checked by immediate assertions.
module tb_vend_ctrl;

    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          coin_valid;
    logic [CW-1:0] coin_val;
    logic          buy_valid;
    logic [2:0]    buy_sel;
    logic          cancel;
    logic          cfg_we;
    logic [2:0]    cfg_addr;
    logic [CW-1:0] cfg_price;
    logic          restock;
    logic          coin_ack;
    logic [CW-1:0] credit;
    logic          busy;
    logic          vend_valid;
    logic [2:0]    vend_type;
    logic          change_valid;
    logic [CW-1:0] change;
    logic          err_valid;
    logic [1:0]    err_code;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vend_ctrl #(.CW(CW), .NPROD(6), .SW(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .coin_valid_i   (coin_valid),
        .coin_val_i     (coin_val),
        .buy_valid_i    (buy_valid),
        .buy_sel_i      (buy_sel),
        .cancel_i       (cancel),
        .cfg_we_i       (cfg_we),
        .cfg_addr_i     (cfg_addr),
        .cfg_price_i    (cfg_price),
        .restock_i      (restock),
        .coin_ack_o     (coin_ack),
        .credit_o       (credit),
        .busy_o         (busy),
        .vend_valid_o   (vend_valid),
        .vend_type_o    (vend_type),
        .change_valid_o (change_valid),
        .change_o       (change),
        .err_valid_o    (err_valid),
        .err_code_o     (err_code)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        coin_valid = 1'b0;
        coin_val   = '0;
        buy_valid  = 1'b0;
        buy_sel    = '0;
        cancel     = 1'b0;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_price  = '0;
        restock    = 1'b0;
    endtask

    // Advance past one rising edge, then drop all one-shot requests
    task automatic tick();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic coin(input logic [CW-1:0] v, input logic exp_ack);
        coin_valid = 1'b1;
        coin_val   = v;
        #1;
        chk("coin_ack", 32'(coin_ack), 32'(exp_ack));
        tick();
    endtask

    task automatic buy(input logic [2:0] s);
        buy_valid = 1'b1;
        buy_sel   = s;
        tick();
    endtask

    task automatic err_check(input string tag, input logic [1:0] code, input logic [CW-1:0] cr);
        chk({tag, "_err_valid"}, 32'(err_valid), 32'd1);
        chk({tag, "_err_code"}, 32'(err_code), 32'(code));
        chk({tag, "_credit"}, 32'(credit), 32'(cr));
    endtask

    // Successful purchase: VEND cycle, vend pulse, then optional change pulse
    task automatic vend_seq(input logic [2:0] s, input logic [CW-1:0] rem);
        buy(s);
        chk("vs_busy_vend", 32'(busy), 32'd1);
        chk("vs_vend_early", 32'(vend_valid), 32'd0);
        tick();
        chk("vs_vend_valid", 32'(vend_valid), 32'd1);
        chk("vs_vend_type", 32'(vend_type), 32'(s));
        chk("vs_credit_after", 32'(credit), 32'(rem));
        chk("vs_busy_after", 32'(busy), 32'(rem != '0));
        tick();
        chk("vs_vend_once", 32'(vend_valid), 32'd0);
        chk("vs_change_valid", 32'(change_valid), 32'(rem != '0));
        if (rem != '0) begin
            chk("vs_change", 32'(change), 32'(rem));
        end
        chk("vs_credit_final", 32'(credit), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_credit", 32'(credit), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vend_valid", 32'(vend_valid), 32'd0);
        chk("rst_vend_type", 32'(vend_type), 32'd0);
        chk("rst_change_valid", 32'(change_valid), 32'd0);
        chk("rst_change", 32'(change), 32'd0);
        chk("rst_err_valid", 32'(err_valid), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        rst_n = 1'b1;
        tick();

        // Exact change on product 2; coin offered during VEND is ignored
        coin(8'd100, 1'b1);
        chk("t1_credit100", 32'(credit), 32'd100);
        coin(8'd50, 1'b1);
        chk("t1_credit150", 32'(credit), 32'd150);
        buy(3'd2);
        chk("t1_busy", 32'(busy), 32'd1);
        coin_valid = 1'b1;
        coin_val   = 8'd10;
        #1;
        chk("t1_ack_in_vend", 32'(coin_ack), 32'd0);
        tick();
        chk("t1_vend_valid", 32'(vend_valid), 32'd1);
        chk("t1_vend_type", 32'(vend_type), 32'd2);
        chk("t1_credit0", 32'(credit), 32'd0);
        chk("t1_busy_done", 32'(busy), 32'd0);
        tick();
        chk("t1_no_change", 32'(change_valid), 32'd0);
        chk("t1_credit_still0", 32'(credit), 32'd0);

        // Vend with change: 250 - 110 = 140
        coin(8'd200, 1'b1);
        coin(8'd50, 1'b1);
        vend_seq(3'd1, 8'd140);

        // Overflow then full refund
        coin(8'd200, 1'b1);
        coin(8'd50, 1'b1);
        coin(8'd10, 1'b0);
        err_check("t3_ovf", 2'd0, 8'd250);
        cancel = 1'b1;
        tick();
        chk("t3_err_once", 32'(err_valid), 32'd0);
        chk("t3_busy_refund", 32'(busy), 32'd1);
        tick();
        chk("t3_change_valid", 32'(change_valid), 32'd1);
        chk("t3_change", 32'(change), 32'd250);
        chk("t3_credit0", 32'(credit), 32'd0);

        // Insufficient funds, bad selections, cancel beats coin
        coin(8'd100, 1'b1);
        buy(3'd1);
        err_check("t4_funds", 2'd3, 8'd100);
        buy(3'd7);
        err_check("t4_badsel7", 2'd1, 8'd100);
        buy(3'd0);
        err_check("t4_badsel0", 2'd1, 8'd100);
        coin_valid = 1'b1;
        coin_val   = 8'd20;
        cancel     = 1'b1;
        #1;
        chk("t4_ack_vs_cancel", 32'(coin_ack), 32'd0);
        tick();
        chk("t4_credit_kept", 32'(credit), 32'd100);
        tick();
        chk("t4_change_valid", 32'(change_valid), 32'd1);
        chk("t4_change", 32'(change), 32'd100);

        // Zero-value coin and cancel while idle do nothing visible
        coin(8'd0, 1'b1);
        chk("t5_credit0", 32'(credit), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        cancel = 1'b1;
        tick();
        chk("t5_cancel_busy", 32'(busy), 32'd0);
        tick();
        chk("t5_cancel_no_change", 32'(change_valid), 32'd0);

        // Price writes: honoured in IDLE, dropped in ACCUM; free item
        cfg_we    = 1'b1;
        cfg_addr  = 3'd3;
        cfg_price = 8'd50;
        tick();
        coin(8'd50, 1'b1);
        vend_seq(3'd3, 8'd0);
        coin(8'd50, 1'b1);
        cfg_we    = 1'b1;
        cfg_addr  = 3'd3;
        cfg_price = 8'd10;
        tick();
        vend_seq(3'd3, 8'd0);
        cfg_we    = 1'b1;
        cfg_addr  = 3'd4;
        cfg_price = 8'd0;
        tick();
        vend_seq(3'd4, 8'd0);

        // Drain product 6 (15 units), then sold out until restocked in IDLE
        for (int k = 0; k < 15; k++) begin
            coin(8'd30, 1'b1);
            vend_seq(3'd6, 8'd0);
        end
        coin(8'd30, 1'b1);
        buy(3'd6);
        err_check("t7_soldout", 2'd2, 8'd30);
        restock = 1'b1;
        tick();
        buy(3'd6);
        err_check("t7_restock_accum", 2'd2, 8'd30);
        cancel = 1'b1;
        tick();
        tick();
        chk("t7_refund", 32'(change), 32'd30);
        restock = 1'b1;
        tick();
        coin(8'd30, 1'b1);
        vend_seq(3'd6, 8'd0);

        // Reset during VEND aborts without pulses and restores prices
        coin(8'd110, 1'b1);
        buy(3'd1);
        chk("t8_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("t8_no_vend", 32'(vend_valid), 32'd0);
        chk("t8_credit0", 32'(credit), 32'd0);
        chk("t8_busy0", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("t8_no_vend_late", 32'(vend_valid), 32'd0);
        chk("t8_no_change", 32'(change_valid), 32'd0);
        coin(8'd50, 1'b1);
        buy(3'd3);
        err_check("t8_price_restored", 2'd3, 8'd50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
